pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_skid_reg_sreg_we.sv | 25 ++
 rtl/pipe_skid_reg.sv | 105 ++++++++++
 tb/tb_pipe_skid_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid pipeline register.
// Exports pipe_skid_state_t (EMPTY / BUSY / FULL occupancy).
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'b00,
      PS_BUSY  = 2'b01,
      PS_FULL  = 2'b10
   } pipe_skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_sreg_we.sv
// sreg_we: write-enabled register, sync active-high reset to 0.
// Ports: clk, rst, we_i (load), d_i (next value), q_o (held value).
module sreg_we #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (we_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid buffer; in_ready from state only.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready (producer);
// out_valid/out_data/out_ready (consumer); flush only with
// PIPE_SKID_REG_FLUSH_EN defined (drops contents, data regs untouched).
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_SKID_REG_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   pipe_skid_state_t state_q, state_d;
   logic [WIDTH-1:0] main_q, skid_q, main_d;
   logic             main_we, skid_we;
   logic             in_fire, out_fire, flush_w;

`ifdef PIPE_SKID_REG_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // 2'b11 is unreachable; it reads as EMPTY (ready, not valid).
   assign in_ready  = (state_q != PS_FULL);
   assign out_valid = (state_q == PS_BUSY) || (state_q == PS_FULL);
   assign out_data  = main_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = in_data;
      main_we = 1'b0;
      skid_we = 1'b0;
      unique case (state_q)
         PS_BUSY: begin
            if (in_fire && !out_fire) begin
               state_d = PS_FULL;
               skid_we = 1'b1;
            end else if (in_fire && out_fire) begin
               main_we = 1'b1;
            end else if (out_fire) begin
               state_d = PS_EMPTY;
            end
         end
         PS_FULL: begin
            if (out_fire) begin
               state_d = PS_BUSY;
               main_d  = skid_q;
               main_we = 1'b1;
            end
         end
         default: begin
            if (in_fire) begin
               state_d = PS_BUSY;
               main_we = 1'b1;
            end
         end
      endcase
      // Flush empties the buffer but leaves data registers as they were.
      if (flush_w) begin
         state_d = PS_EMPTY;
         main_we = 1'b0;
         skid_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   sreg_we #(.WIDTH(WIDTH)) u_main (
      .clk  (clk),
      .rst  (rst),
      .we_i (main_we),
      .d_i  (main_d),
      .q_o  (main_q)
   );

   sreg_we #(.WIDTH(WIDTH)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .we_i (skid_we),
      .d_i  (in_data),
      .q_o  (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model plus directed literal checks.
// Build with or without PIPE_SKID_REG_FLUSH_EN.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        flush = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic [31:0] mq[$];
   logic [31:0] m_last = '0;

   always #5 clk = ~clk;

`ifdef PIPE_SKID_REG_FLUSH_EN
   pipe_skid_reg #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .flush(flush)
   );
`else
   pipe_skid_reg #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );
`endif

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Occupancy model: a FIFO of at most two words.
   always @(posedge clk) begin
      bit inf, outf;
      inf  = in_valid && (mq.size() < 2);
      outf = out_ready && (mq.size() > 0);
      if (mq.size() > 0) m_last = mq[0];
      if (rst) begin
         mq.delete();
         m_last = '0;
      end else if (flush) begin
         mq.delete();
      end else begin
         if (outf) void'(mq.pop_front());
         if (inf) mq.push_back(in_data);
      end
      if (mq.size() > 0) m_last = mq[0];
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
         check("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
         check("m_out_data", out_data, m_last);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
   endtask

   initial begin
      logic [39:0] pv;
      logic [39:0] pr;
      pv = 40'hB7_6E_F1_9D_35;
      pr = 40'h5C_D3_A9_7E_E6;
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 32'hA5;
      out_ready = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_data", out_data, 32'd0);

      // Streaming with 1-cycle latency.
      out_ready = 1'b1;
      push(32'h1); step();
      check("str_1", out_data, 32'h1);
      push(32'h2); step();
      check("str_2", out_data, 32'h2);
      check("str_rdy", {31'b0, in_ready}, 32'd1);
      push(32'h3); step();
      check("str_3", out_data, 32'h3);
      in_valid = 1'b0; step();
      check("str_empty", {31'b0, out_valid}, 32'd0);
      check("str_hold", out_data, 32'h3);

      // Backpressure: second word lands in skid.
      out_ready = 1'b0;
      push(32'h10); step();
      push(32'h11); step();
      check("bp_full", {31'b0, in_ready}, 32'd0);
      check("bp_head", out_data, 32'h10);
      push(32'h12); step();
      check("bp_stall", out_data, 32'h10);
      out_ready = 1'b1; step();
      check("bp_11", out_data, 32'h11);
      step();
      check("bp_12", out_data, 32'h12);
      in_valid = 1'b0; step();
      check("bp_drain", {31'b0, out_valid}, 32'd0);

      // Simultaneous in/out while BUSY.
      out_ready = 1'b0;
      push(32'h20); step();
      out_ready = 1'b1;
      push(32'h21); step();
      check("sim_21", out_data, 32'h21);
      check("sim_busy", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0; step();

      // Reset while FULL loses both words.
      out_ready = 1'b0;
      push(32'h30); step();
      push(32'h31); step();
      rst = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      check("rf_valid", {31'b0, out_valid}, 32'd0);
      check("rf_data", out_data, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rf_gone", {31'b0, out_valid}, 32'd0);
      end

`ifdef PIPE_SKID_REG_FLUSH_EN
      out_ready = 1'b0;
      push(32'h50); step();
      push(32'h51); step();
      flush = 1'b1;
      push(32'h40); step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_empty", {31'b0, out_valid}, 32'd0);
      check("fl_rdy", {31'b0, in_ready}, 32'd1);
      check("fl_data", out_data, 32'h50);
      out_ready = 1'b1; step();
      check("fl_drop", {31'b0, out_valid}, 32'd0);
`endif

      // Toggling handshakes; model checks every cycle.
      for (int i = 0; i < 40; i++) begin
         in_valid  = pv[i];
         in_data   = 32'h100 + 32'(i);
         out_ready = pr[i];
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("final_empty", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
